// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch resolve unit: control-transfer
// opcodes, resolver FSM encoding, default redirect PC and small opcode helpers.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_J    = 3'd3;
  localparam logic [2:0] BR_JAL  = 3'd4;
  localparam logic [2:0] BR_JR   = 3'd5;

  localparam logic [31:0] BR_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } br_state_e;

  // Codes 6/7 are not control transfers and behave like BR_NONE.
  function automatic logic br_is_ctl(input logic [2:0] op);
    return (op >= BR_BEQ) && (op <= BR_JR);
  endfunction

  // Conditional branches and JR depend on forwarded register values.
  function automatic logic br_needs_ops(input logic [2:0] op);
    return (op == BR_BEQ) || (op == BR_BNE) || (op == BR_JR);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational taken/target evaluation for one control-transfer instruction.
// Branch offsets are word-scaled signed immediates; all sums wrap modulo 2^PC_W.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [2:0]      br_op_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [15:0]     imm16_i,
  input  logic [25:0]     index_i,
  input  logic [31:0]     rs_val_i,
  input  logic            beq_zero_i,
  output logic            taken_o,
  output logic [PC_W-1:0] target_o
);

  logic signed [PC_W-1:0] offset;
  logic [PC_W-1:0]        seq_pc;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        j_tgt;

  // Compute every candidate target, then pick by opcode.
  always_comb begin
    offset   = signed'({{(PC_W-18){imm16_i[15]}}, imm16_i, 2'b00});
    seq_pc   = pc_i + PC_W'(4);
    br_tgt   = seq_pc + $unsigned(offset);
    j_tgt    = {pc_i[PC_W-1:28], index_i, 2'b00};
    taken_o  = 1'b0;
    target_o = seq_pc;
    case (br_op_i)
      BR_BEQ: begin
        taken_o  = beq_zero_i;
        target_o = br_tgt;
      end
      BR_BNE: begin
        taken_o  = !beq_zero_i;
        target_o = br_tgt;
      end
      BR_J, BR_JAL: begin
        taken_o  = 1'b1;
        target_o = j_tgt;
      end
      BR_JR: begin
        taken_o  = 1'b1;
        target_o = rs_val_i[PC_W-1:0];
      end
      default: begin
        taken_o  = 1'b0;
        target_o = seq_pc;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver. Holds a control-transfer instruction until its
// operands are forwarded, then emits a one-cycle registered redirect to IF.
// The delay slot is architectural and never flushed.
// Optional build macro BRANCH_STATS_EN adds taken/not-taken/wait-cycle counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(BR_RESET_PC),
  parameter int              MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [2:0]      br_op,
  input  logic [PC_W-1:0] pc_id,
  input  logic [15:0]     imm16,
  input  logic [25:0]     instr_index,
  input  logic [31:0]     rs_val,
  input  logic            operands_rdy,
  input  logic            beq_zero,
  output logic            stall_req,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            link_we,
  output logic            stall_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_not_taken,
  output logic [31:0]     stat_wait_cycles
`endif
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  // Wait counter saturates at MAX_WAIT so a long stall cannot wrap it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_WAIT)) return c;
    return c + CNT_W'(1);
  endfunction

  br_state_e       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic            stall_err_q;
  logic            redirect_valid_q;
  logic            link_we_q;
  logic [PC_W-1:0] redirect_pc_q;

  // Fields of the instruction parked in WAIT (ID inputs are ignored there).
  logic [2:0]      op_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     imm_q;
  logic [25:0]     idx_q;

  logic            live_ctl;
  logic            live_hold;
  logic            resolve_w;
  logic            stall_w;
  logic [2:0]      calc_op;
  logic [PC_W-1:0] calc_pc;
  logic [15:0]     calc_imm;
  logic [25:0]     calc_idx;
  logic            taken_w;
  logic [PC_W-1:0] target_w;
  logic [CNT_W-1:0] wait_inc;

  // Select live or parked fields, decide resolve and the combinational stall.
  // Stall follows "branch in ID cannot resolve this cycle", so it drops in the
  // same cycle operands_rdy rises and the delay slot advances with the branch.
  always_comb begin
    live_ctl  = id_valid && br_is_ctl(br_op);
    live_hold = live_ctl && br_needs_ops(br_op) && !operands_rdy;
    calc_op   = br_op;
    calc_pc   = pc_id;
    calc_imm  = imm16;
    calc_idx  = instr_index;
    resolve_w = 1'b0;
    stall_w   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        resolve_w = live_ctl && !live_hold;
        stall_w   = live_hold;
      end
      ST_WAIT: begin
        calc_op   = op_q;
        calc_pc   = pc_q;
        calc_imm  = imm_q;
        calc_idx  = idx_q;
        resolve_w = operands_rdy;
        stall_w   = !operands_rdy;
      end
      default: begin
        resolve_w = 1'b0;
        stall_w   = 1'b0;
      end
    endcase
    if (reset) stall_w = 1'b0;
    wait_inc = sat_inc(wait_cnt_q);
  end

  branch_target_calc #(
    .PC_W (PC_W)
  ) u_target (
    .br_op_i    (calc_op),
    .pc_i       (calc_pc),
    .imm16_i    (calc_imm),
    .index_i    (calc_idx),
    .rs_val_i   (rs_val),
    .beq_zero_i (beq_zero),
    .taken_o    (taken_w),
    .target_o   (target_w)
  );

  // Park the ID fields while idle so WAIT resolves the original instruction.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) begin
      op_q  <= br_op;
      pc_q  <= pc_id;
      imm_q <= imm16;
      idx_q <= instr_index;
    end
  end

  // Resolver FSM with its registered redirect/link outputs and wait watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      wait_cnt_q       <= '0;
      stall_err_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      link_we_q        <= 1'b0;
      redirect_pc_q    <= RESET_PC;
    end else begin
      redirect_valid_q <= resolve_w && taken_w;
      link_we_q        <= resolve_w && (calc_op == BR_JAL);
      if (resolve_w) redirect_pc_q <= target_w;
      case (state_q)
        ST_IDLE: begin
          if (live_hold) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
          end else if (resolve_w) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (resolve_w) begin
            state_q <= ST_ISSUE;
          end else begin
            wait_cnt_q <= wait_inc;
            if (wait_inc >= CNT_W'(MAX_WAIT)) stall_err_q <= 1'b1;
          end
        end
        ST_ISSUE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_not_taken_q;
  logic [31:0] stat_wait_q;

  // Event counters: one count per ISSUE outcome and per cycle spent in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
      stat_wait_q      <= '0;
    end else begin
      if (state_q == ST_ISSUE) begin
        if (redirect_valid_q) stat_taken_q <= stat_taken_q + 32'd1;
        else                  stat_not_taken_q <= stat_not_taken_q + 32'd1;
      end
      if (state_q == ST_WAIT) stat_wait_q <= stat_wait_q + 32'd1;
    end
  end

  assign stat_taken       = stat_taken_q;
  assign stat_not_taken   = stat_not_taken_q;
  assign stat_wait_cycles = stat_wait_q;
`endif

  assign stall_req      = stall_w;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign link_we        = link_we_q;
  assign stall_err      = stall_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected redirects,
// one task per scenario. Stats scenario only built when BRANCH_STATS_EN is defined.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [2:0]  br_op;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic        operands_rdy;
  logic        beq_zero;
  logic        stall_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic        stall_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
  logic [31:0] stat_wait_cycles;
`endif

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        link;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_resolve_unit #(
    .PC_W     (32),
    .RESET_PC (32'h0000_3000),
    .MAX_WAIT (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .br_op          (br_op),
    .pc_id          (pc_id),
    .imm16          (imm16),
    .instr_index    (instr_index),
    .rs_val         (rs_val),
    .operands_rdy   (operands_rdy),
    .beq_zero       (beq_zero),
    .stall_req      (stall_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .stall_err      (stall_err)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken       (stat_taken),
    .stat_not_taken   (stat_not_taken),
    .stat_wait_cycles (stat_wait_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    id_valid     = 1'b0;
    br_op        = BR_NONE;
    pc_id        = 32'h0;
    imm16        = 16'h0;
    instr_index  = 26'h0;
    rs_val       = 32'h0;
    operands_rdy = 1'b0;
    beq_zero     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the redirect an instruction should produce.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] pc,
                                 input logic [15:0] imm, input logic [25:0] idx,
                                 input logic [31:0] rs, input logic zero);
    exp_t e;
    int   off;
    off    = $signed(imm);
    e.link = (op == BR_JAL);
    e.vld  = 1'b0;
    e.pc   = 32'h0;
    case (op)
      BR_BEQ: begin e.vld = zero;  e.pc = pc + 32'd4 + 32'(off * 4); end
      BR_BNE: begin e.vld = !zero; e.pc = pc + 32'd4 + 32'(off * 4); end
      BR_J, BR_JAL: begin e.vld = 1'b1; e.pc = (pc & 32'hF000_0000) | (32'(idx) << 2); end
      BR_JR: begin e.vld = 1'b1; e.pc = rs; end
      default: e.vld = 1'b0;
    endcase
    return e;
  endfunction

  // Present one branch in ID, hold operands back k cycles, then check the issue cycle.
  task automatic drive_branch(input string nm, input logic [2:0] op, input logic [31:0] pc,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic zero, input int k_in);
    exp_t e;
    int   k;
    logic needs;
    logic exp_stall;
    needs = (op == BR_BEQ) || (op == BR_BNE) || (op == BR_JR);
    k     = needs ? k_in : 0;
    exp_q.push_back(model(op, pc, imm, idx, rs, zero));
    for (int c = 0; c <= k; c++) begin
      if (c == 0) begin
        id_valid = 1'b1; br_op = op; pc_id = pc; imm16 = imm; instr_index = idx;
      end else begin
        id_valid    = 1'($urandom_range(0, 1));
        br_op       = 3'($urandom_range(0, 7));
        pc_id       = $urandom;
        imm16       = 16'($urandom);
        instr_index = 26'($urandom);
      end
      operands_rdy = (c == k);
      beq_zero     = (c == k) ? zero : 1'($urandom_range(0, 1));
      rs_val       = (c == k) ? rs : $urandom;
      @(negedge clk);
      exp_stall = needs && (c < k);
      n_checks++;
      if (stall_req !== exp_stall) begin
        n_fail++;
        $display("FAIL %s stall cycle %0d: got %b expected %b", nm, c, stall_req, exp_stall);
      end
      next_cycle();
    end
    // Issue cycle; a stray branch sits in the delay slot and must be ignored.
    id_valid = 1'b1; br_op = BR_BEQ; pc_id = 32'h0000_5000; imm16 = 16'h0010;
    operands_rdy = 1'b0; beq_zero = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (redirect_valid !== e.vld) begin
      n_fail++;
      $display("FAIL %s redirect_valid: got %b expected %b", nm, redirect_valid, e.vld);
    end
    if (e.vld) begin
      n_checks++;
      if (redirect_pc !== e.pc) begin
        n_fail++;
        $display("FAIL %s redirect_pc: got %h expected %h", nm, redirect_pc, e.pc);
      end
    end
    n_checks++;
    if (link_we !== e.link) begin
      n_fail++;
      $display("FAIL %s link_we: got %b expected %b", nm, link_we, e.link);
    end
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issue stall: got %b expected 0", nm, stall_req);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, link_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s pulse width: got rv=%b lw=%b expected 0/0", nm, redirect_valid, link_we);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    id_valid = 1'b1; br_op = BR_BEQ; operands_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({stall_req, redirect_valid, link_we, stall_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset outputs: got stall=%b rv=%b lw=%b err=%b expected all 0",
               stall_req, redirect_valid, link_we, stall_err);
    end
    n_checks++;
    if (redirect_pc !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL reset redirect_pc: got %h expected 00003000", redirect_pc);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_beq_taken();
    drive_branch("beq_taken", BR_BEQ, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_bne_not_taken();
    drive_branch("bne_not_taken", BR_BNE, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b1, 0);
    drive_branch("bne_wrap", BR_BNE, 32'h0000_0004, 16'h8000, 26'h0, 32'h0, 1'b0, 1);
  endtask

  task automatic test_beq_wait();
    drive_branch("beq_wait2", BR_BEQ, 32'h0000_3010, 16'hFFFF, 26'h0, 32'h0, 1'b1, 2);
    drive_branch("beq_nt_wait", BR_BEQ, 32'h0000_3010, 16'h0020, 26'h0, 32'h0, 1'b0, 1);
  endtask

  task automatic test_jumps();
    drive_branch("jal", BR_JAL, 32'h0000_3000, 16'h0, 26'h0000C10, 32'h0, 1'b0, 0);
    drive_branch("jr", BR_JR, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3100, 1'b0, 0);
    drive_branch("jr_wait", BR_JR, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_4440, 1'b0, 3);
    drive_branch("j_region", BR_J, 32'hA000_1234, 16'h0, 26'h3FFFFFF, 32'h0, 1'b0, 2);
  endtask

  task automatic test_idle_quiet();
    logic [2:0] ops [4];
    logic       vals [4];
    ops  = '{BR_BEQ, BR_JR, 3'd6, 3'd7};
    vals = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      id_valid = vals[i]; br_op = ops[i]; operands_rdy = 1'b0; beq_zero = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stall_req !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet stall op=%0d: got %b expected 0", ops[i], stall_req);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, link_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_quiet redirect op=%0d: got rv=%b lw=%b expected 0/0",
                 ops[i], redirect_valid, link_we);
      end
      next_cycle();
    end
  endtask

  task automatic test_max_wait_edge();
    drive_branch("wait_max", BR_BEQ, 32'h0000_3100, 16'h0002, 26'h0, 32'h0, 1'b1, 4);
    @(negedge clk);
    n_checks++;
    if (stall_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_max stall_err: got %b expected 0", stall_err);
    end
    next_cycle();
  endtask

  task automatic test_stall_err();
    logic exp_err;
    id_valid = 1'b1; br_op = BR_BNE; pc_id = 32'h0000_3200; imm16 = 16'h0008;
    operands_rdy = 1'b0; beq_zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_err = (c >= 5);
      n_checks++;
      if (stall_req !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_err hold cycle %0d: stall got %b expected 1", c, stall_req);
      end
      n_checks++;
      if (stall_err !== exp_err) begin
        n_fail++;
        $display("FAIL stall_err cycle %0d: got %b expected %b", c, stall_err, exp_err);
      end
      next_cycle();
      id_valid = 1'b0;
    end
    // Asynchronous reset mid-WAIT with the branch still unresolved.
    id_valid = 1'b1; br_op = BR_BNE;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({stall_req, redirect_valid, link_we, stall_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async reset outputs: got stall=%b rv=%b lw=%b err=%b expected all 0",
               stall_req, redirect_valid, link_we, stall_err);
    end
    n_checks++;
    if (redirect_pc !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL async reset redirect_pc: got %h expected 00003000", redirect_pc);
    end
    next_cycle();
    idle_inputs();
    operands_rdy = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, stall_err, stall_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL post-reset cycle %0d: got rv=%b err=%b stall=%b expected 0/0/0",
                 c, redirect_valid, stall_err, stall_req);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    next_cycle();
    drive_branch("st_beq", BR_BEQ, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b1, 3);
    drive_branch("st_j", BR_J, 32'h0000_3000, 16'h0, 26'h0000100, 32'h0, 1'b0, 0);
    drive_branch("st_jr", BR_JR, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3300, 1'b0, 0);
    drive_branch("st_beq_nt", BR_BEQ, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b0, 0);
    drive_branch("st_bne_nt", BR_BNE, 32'h0000_3010, 16'h0004, 26'h0, 32'h0, 1'b1, 0);
    @(negedge clk);
    n_checks++;
    if (stat_taken !== 32'd3) begin
      n_fail++;
      $display("FAIL stat_taken: got %0d expected 3", stat_taken);
    end
    n_checks++;
    if (stat_not_taken !== 32'd2) begin
      n_fail++;
      $display("FAIL stat_not_taken: got %0d expected 2", stat_not_taken);
    end
    n_checks++;
    if (stat_wait_cycles !== 32'd3) begin
      n_fail++;
      $display("FAIL stat_wait_cycles: got %0d expected 3", stat_wait_cycles);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_beq_wait();
    test_jumps();
    test_idle_quiet();
    test_max_wait_edge();
    test_stall_err();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
